// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the host-side knight's-tour command link.
package remote_comm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TX_HI,
        TX_LO,
        WAIT_RESP
    } rc_state_t;

    // Robot's positive-acknowledge response byte.
    localparam logic [7:0] RESP_ACK = 8'hA5;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART transmitter plus receiver. tx_done holds until the next trmt,
// and rx_rdy holds until clr_rx_rdy.
module UART #(
    parameter int unsigned BAUD_CYC = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    input  logic       RX,
    input  logic       clr_rx_rdy,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);

    localparam int unsigned BW = $clog2(BAUD_CYC);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CYC - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_CYC / 2 - 1);

    logic [8:0]    tx_shift_q, tx_shift_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [BW-1:0] tx_baud_q, tx_baud_d;
    logic          tx_busy_q, tx_busy_d;
    logic          tx_done_q, tx_done_d;

    logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic          rx_busy_q, rx_busy_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [BW-1:0] rx_baud_q, rx_baud_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_rdy_q, rx_rdy_d;
    logic [7:0]    rx_data_q, rx_data_d;

    // Transmit: start bit sits in shift[0]; ones shift in behind so the line ends high.
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_baud_d  = tx_baud_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = tx_done_q;
        if (trmt) begin
            tx_shift_d = {tx_data, 1'b0};
            tx_bit_d   = '0;
            tx_baud_d  = '0;
            tx_busy_d  = 1'b1;
            tx_done_d  = 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BAUD_LAST) begin
                tx_baud_d  = '0;
                tx_shift_d = {1'b1, tx_shift_q[8:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_done_d = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_d = tx_baud_q + 1'b1;
            end
        end
    end

    // Receive: sample mid-bit; a start bit that is high again at mid-point is discarded.
    always_comb begin
        rx_s1_d    = RX;
        rx_s2_d    = rx_s1_q;
        rx_busy_d  = rx_busy_q;
        rx_bit_d   = rx_bit_q;
        rx_baud_d  = rx_baud_q;
        rx_shift_d = rx_shift_q;
        rx_rdy_d   = rx_rdy_q;
        rx_data_d  = rx_data_q;
        if (clr_rx_rdy) rx_rdy_d = 1'b0;
        if (!rx_busy_q) begin
            if (!rx_s2_q) begin
                rx_busy_d = 1'b1;
                rx_bit_d  = '0;
                rx_baud_d = BAUD_HALF;
            end
        end else if (rx_baud_q == '0) begin
            rx_baud_d = BAUD_LAST;
            rx_bit_d  = rx_bit_q + 4'd1;
            if (rx_bit_q == 4'd0) begin
                if (rx_s2_q) rx_busy_d = 1'b0;
            end else if (rx_bit_q == 4'd9) begin
                rx_busy_d = 1'b0;
                if (rx_s2_q) begin
                    rx_rdy_d  = 1'b1;
                    rx_data_d = rx_shift_q;
                end
            end else begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            end
        end else begin
            rx_baud_d = rx_baud_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_baud_q  <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_bit_q   <= '0;
            rx_baud_q  <= '0;
            rx_shift_q <= '0;
            rx_rdy_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_baud_q  <= tx_baud_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_busy_q  <= rx_busy_d;
            rx_bit_q   <= rx_bit_d;
            rx_baud_q  <= rx_baud_d;
            rx_shift_q <= rx_shift_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;
    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_data_q;

endmodule

// File: rtl/remote_comm.sv
// Host-side command transmitter: sends a 16-bit command as two UART frames
// (high byte first) and waits, with a timeout, for a one-byte response.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned BAUD_CYC    = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        cmd_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    rc_state_t        state_q, state_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [7:0]       resp_q, resp_d;
    logic             resp_rdy_q, resp_rdy_d;
    logic             cmd_snt_q, cmd_snt_d;
    logic             timeout_q, timeout_d;
    logic             trmt_q, trmt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;

    UART #(.BAUD_CYC(BAUD_CYC)) u_uart (
        .clk       (clk),
        .rst       (rst),
        .trmt      (trmt_q),
        .tx_data   (tx_data),
        .TX        (TX),
        .tx_done   (tx_done),
        .RX        (RX),
        .clr_rx_rdy(clr_rx_rdy),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data)
    );

    assign tx_data = (state_q == TX_LO) ? cmd_q[7:0] : cmd_q[15:8];
    // Every received byte is consumed at once; outside WAIT_RESP it is simply dropped.
    assign clr_rx_rdy = rx_rdy;

    // trmt_q marks the first cycle of TX_HI/TX_LO, when a stale tx_done must be ignored.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        cmd_snt_d  = cmd_snt_q;
        timeout_d  = timeout_q;
        trmt_d     = 1'b0;
        cnt_d      = cnt_q;
        if (clr_resp_rdy) resp_rdy_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    cmd_d      = cmd;
                    cmd_snt_d  = 1'b0;
                    resp_rdy_d = 1'b0;
                    timeout_d  = 1'b0;
                    trmt_d     = 1'b1;
                    state_d    = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_done && !trmt_q) begin
                    trmt_d  = 1'b1;
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_done && !trmt_q) begin
                    cmd_snt_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (rx_rdy) begin
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
            cmd_snt_q  <= 1'b0;
            timeout_q  <= 1'b0;
            trmt_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
            cmd_snt_q  <= cmd_snt_d;
            timeout_q  <= timeout_d;
            trmt_q     <= trmt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cmd_snt  = cmd_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;
    assign timeout  = timeout_q;
    assign busy     = (state_q != IDLE);

endmodule
